// File: rtl/car_park_ctrl_mc.sv
// Car park gate controller: authenticates drivers against a credential table, locks out after
// repeated failures, commits occupancy on pass-through and flags tailgating.
module car_park_ctrl_mc #(
  parameter int                          CAPACITY     = 8,
  parameter int                          CNT_W        = $clog2(CAPACITY + 1),
  parameter int                          PASS_W       = 4,
  parameter int                          N_USERS      = 2,
  parameter logic [N_USERS*PASS_W-1:0]   CRED_USER    = {4'h5, 4'h3},
  parameter logic [N_USERS*PASS_W-1:0]   CRED_PASS    = {4'hA, 4'h5},
  parameter int                          TIMEOUT      = 16,
  parameter int                          MAX_TRIES    = 3,
  parameter int                          LOCK_CYCLES  = 64,
  parameter int                          GATE_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entrance_front,
  input  logic              entrance_back,
  input  logic              exit,
  input  logic              cred_valid,
  input  logic [PASS_W-1:0] user,
  input  logic [PASS_W-1:0] password,
  output logic              led_red,
  output logic              led_green,
  output logic              gate_open,
  output logic              alarm,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  spots_available,
  output logic              full
);

  localparam int T_AB    = (TIMEOUT > GATE_TIMEOUT) ? TIMEOUT : GATE_TIMEOUT;
  localparam int T_MAX   = (T_AB > LOCK_CYCLES) ? T_AB : LOCK_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  localparam logic [CNT_W-1:0]   CAP_C       = CNT_W'(CAPACITY);
  localparam logic [TIMER_W-1:0] WAIT_LAST   = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GATE_LAST   = TIMER_W'(GATE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [TRY_W-1:0]   TRIES_LIMIT = TRY_W'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PASS = 3'd1,
    GRANTED   = 3'd2,
    LOCKED    = 3'd3,
    TAILGATE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               commit;
  logic               table_hit;
  logic               match;
  logic               full_w;

  always_comb begin
    table_hit = 1'b0;
    for (int i = 0; i < N_USERS; i++) begin
      if (user == CRED_USER[i*PASS_W +: PASS_W] && password == CRED_PASS[i*PASS_W +: PASS_W])
        table_hit = 1'b1;
    end
  end

  assign match  = cred_valid && table_hit;
  assign full_w = (occ_q == CAP_C);

  // State and datapath registers; reset aborts any transaction and forgets occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      tries_q <= '0;
      occ_q   <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values regardless of order.
      state_q <= state_d;
      timer_q <= timer_d;
      tries_q <= tries_d;
      occ_q   <= occ_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    state_d = state_q;
    tries_d = tries_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (entrance_front && !full_w) begin
          state_d = WAIT_PASS;
          tries_d = '0;
        end
      end
      WAIT_PASS: begin
        if (cred_valid) begin
          if (match) begin
            state_d = GRANTED;
          end else begin
            tries_d = tries_q + TRY_W'(1);
            if (tries_d == TRIES_LIMIT) state_d = LOCKED;
          end
        end else if (timer_q == WAIT_LAST) begin
          state_d = IDLE;
        end
      end
      GRANTED: begin
        if (entrance_back && !entrance_front) begin
          state_d = IDLE;
          commit  = 1'b1;
        end else if (entrance_back && entrance_front) begin
          state_d = TAILGATE;
        end else if (timer_q == GATE_LAST) begin
          state_d = IDLE;
        end
      end
      TAILGATE: begin
        // Only the authorised car is counted; the tailgater is reported, not committed.
        if (!entrance_front) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      LOCKED: begin
        if (timer_q == LOCK_LAST) begin
          state_d = IDLE;
          tries_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One shared timer, restarted on every state change.
  assign timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + TIMER_W'(1);

  always_comb begin
    occ_d = occ_q;
    if (commit && !exit && occ_q != CAP_C)
      occ_d = occ_q + CNT_W'(1);
    else if (!commit && exit && occ_q != '0)
      occ_d = occ_q - CNT_W'(1);
  end

  always_comb begin
    led_red   = 1'b0;
    led_green = 1'b0;
    gate_open = 1'b0;
    alarm     = 1'b0;
    case (state_q)
      IDLE:      led_red = entrance_front && full_w;
      WAIT_PASS: led_red = 1'b1;
      GRANTED: begin
        led_green = 1'b1;
        gate_open = 1'b1;
      end
      LOCKED, TAILGATE: begin
        led_red = 1'b1;
        alarm   = 1'b1;
      end
      default: ;
    endcase
  end

  assign state           = state_q;
  assign spots_available = CAP_C - occ_q;
  assign full            = full_w;

endmodule
